// File: rtl/cartridge_bus_pkg.sv
// Shared types and constants for the cartridge bus engine: FSM states, SRAM select decode and
// the request bundle.
package cartridge_bus_pkg;

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} cart_state_e;

  localparam logic [2:0]  CS_ADDR_HI  = 3'b101;
  localparam int unsigned CS_ADDR_MSB = 15;
  localparam int unsigned CS_ADDR_LSB = 13;

  typedef struct packed {
    logic        write;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  len;
  } cart_req_t;

  function automatic logic sram_sel(input logic [15:0] addr);
    return addr[CS_ADDR_MSB:CS_ADDR_LSB] == CS_ADDR_HI;
  endfunction

  function automatic int unsigned timer_width(input int unsigned s, input int unsigned t,
                                              input int unsigned h);
    int unsigned m;
    m = (s > t) ? s : t;
    m = (m > h) ? m : h;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/cart_bus_phase_timer.sv
// Loadable down-counter timing one bus phase; done_o is high once the count reaches zero.
module cart_bus_phase_timer #(
  parameter int unsigned Width = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             done_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/cartridge_bus_engine.sv
// Game Boy cartridge bus sequencer: SETUP/STROBE/HOLD cycles with registered strobes.
// Define CART_BUS_BURST_EN to honour req_len_i for auto-incrementing read bursts.
module cartridge_bus_engine
  import cartridge_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES  = 2,
  parameter int unsigned STROBE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input  logic        clock_i,
  input  logic        reset_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [15:0] req_addr_i,
  input  logic [7:0]  req_wdata_i,
  input  logic [7:0]  req_len_i,
  output logic        resp_valid_o,
  output logic [7:0]  resp_rdata_o,
  output logic        resp_last_o,
  output logic [15:0] cart_a_o,
  output logic [7:0]  cart_d_out_o,
  output logic        cart_d_oe_o,
  input  logic [7:0]  cart_d_in_i,
  output logic        cart_nrd_o,
  output logic        cart_nwr_o,
  output logic        cart_ncs_o,
  output logic        cart_phi_o,
  output logic        dir_a_lo_o,
  output logic        dir_a_hi_o,
  output logic        dir_ctrl_o,
  output logic        dir_d_o,
  output logic        shifter_n_oe_o
);

  localparam int unsigned CntW = timer_width(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
  localparam logic [CntW-1:0] SetupLd  = CntW'(SETUP_CYCLES - 1);
  localparam logic [CntW-1:0] StrobeLd = CntW'(STROBE_CYCLES - 1);
  localparam logic [CntW-1:0] HoldLd   = CntW'(HOLD_CYCLES - 1);

  cart_state_e state_q;
  cart_req_t   req;
  logic        write_q, shifter_n_oe_q;
  logic [15:0] cart_a_q;
  logic [7:0]  cart_d_out_q, rdata_q, resp_rdata_q;
  logic        cart_d_oe_q, dir_d_q, nrd_q, nwr_q, ncs_q, phi_q;
  logic        resp_valid_q, resp_last_q;
  logic        accept, last_beat, tmr_done, tmr_load;
  logic [CntW-1:0] tmr_val;

  assign req = '{write: req_write_i, addr: req_addr_i, wdata: req_wdata_i, len: req_len_i};

`ifdef CART_BUS_BURST_EN
  logic [7:0] beats_q;
  assign last_beat = (beats_q == 8'd0);
`else
  logic unused_len;
  assign unused_len = ^req.len;
  assign last_beat  = 1'b1;
`endif

  // Ready also in the final HOLD cycle so a waiting request starts SETUP with no idle gap.
  assign req_ready_o = !shifter_n_oe_q &&
                       ((state_q == StIdle) || (state_q == StHold && tmr_done && last_beat));
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (tmr_done) begin
      case (state_q)
        StSetup:  begin tmr_load = 1'b1; tmr_val = StrobeLd; end
        StStrobe: begin tmr_load = 1'b1; tmr_val = HoldLd;   end
        StHold:   if (!last_beat) begin tmr_load = 1'b1; tmr_val = SetupLd; end
        default:  ;
      endcase
    end
    if (accept) begin
      tmr_load = 1'b1;
      tmr_val  = SetupLd;
    end
  end

  cart_bus_phase_timer #(
    .Width(CntW)
  ) u_timer (
    .clk_i     (clock_i),
    .rst_ni    (reset_ni),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .done_o    (tmr_done)
  );

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      state_q        <= StIdle;
      write_q        <= 1'b0;
      cart_a_q       <= 16'h0000;
      cart_d_out_q   <= 8'h00;
      cart_d_oe_q    <= 1'b0;
      dir_d_q        <= 1'b0;
      nrd_q          <= 1'b1;
      nwr_q          <= 1'b1;
      ncs_q          <= 1'b1;
      phi_q          <= 1'b0;
      rdata_q        <= 8'h00;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= 8'h00;
      resp_last_q    <= 1'b0;
      shifter_n_oe_q <= 1'b1;
`ifdef CART_BUS_BURST_EN
      beats_q        <= 8'd0;
`endif
    end else begin
      shifter_n_oe_q <= 1'b0;
      resp_valid_q   <= 1'b0;
      case (state_q)
        StSetup: if (tmr_done) begin
          state_q <= StStrobe;
          nrd_q   <= write_q;
          nwr_q   <= !write_q;
          phi_q   <= 1'b1;
        end
        StStrobe: if (tmr_done) begin
          state_q <= StHold;
          nrd_q   <= 1'b1;
          nwr_q   <= 1'b1;
          phi_q   <= 1'b0;
          rdata_q <= cart_d_in_i;
        end
        StHold: if (tmr_done) begin
          resp_valid_q <= 1'b1;
          resp_last_q  <= last_beat;
          resp_rdata_q <= write_q ? 8'h00 : rdata_q;
          if (!last_beat) begin
            state_q  <= StSetup;
            cart_a_q <= cart_a_q + 16'd1;
            ncs_q    <= !sram_sel(cart_a_q + 16'd1);
`ifdef CART_BUS_BURST_EN
            beats_q  <= beats_q - 8'd1;
`endif
          end else begin
            state_q     <= StIdle;
            cart_d_oe_q <= 1'b0;
            dir_d_q     <= 1'b0;
            ncs_q       <= 1'b1;
          end
        end
        default: ;
      endcase
      // A new request overrides the idle/last-HOLD updates above.
      if (accept) begin
        state_q     <= StSetup;
        write_q     <= req.write;
        cart_a_q    <= req.addr;
        ncs_q       <= !sram_sel(req.addr);
        cart_d_oe_q <= req.write;
        dir_d_q     <= req.write;
        if (req.write) cart_d_out_q <= req.wdata;
`ifdef CART_BUS_BURST_EN
        beats_q     <= req.write ? 8'd0 : req.len;
`endif
      end
    end
  end

  assign resp_valid_o   = resp_valid_q;
  assign resp_rdata_o   = resp_rdata_q;
  assign resp_last_o    = resp_last_q;
  assign cart_a_o       = cart_a_q;
  assign cart_d_out_o   = cart_d_out_q;
  assign cart_d_oe_o    = cart_d_oe_q;
  assign cart_nrd_o     = nrd_q;
  assign cart_nwr_o     = nwr_q;
  assign cart_ncs_o     = ncs_q;
  assign cart_phi_o     = phi_q;
  assign dir_a_lo_o     = 1'b1;
  assign dir_a_hi_o     = 1'b1;
  assign dir_ctrl_o     = 1'b1;
  assign dir_d_o        = dir_d_q;
  assign shifter_n_oe_o = shifter_n_oe_q;

endmodule

// File: tb/tb_cartridge_bus_engine.sv
// Directed bench for cartridge_bus_engine with default timing (S=2, T=4, H=1).
module tb_cartridge_bus_engine;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata, req_len;
  logic        resp_valid, resp_last;
  logic [7:0]  resp_rdata;
  logic [15:0] cart_a;
  logic [7:0]  cart_d_out, cart_d_in;
  logic        cart_d_oe, cart_nrd, cart_nwr, cart_ncs, cart_phi;
  logic        dir_a_lo, dir_a_hi, dir_ctrl, dir_d, shifter_n_oe;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  logic [31:0] m_nrd, m_nwr, m_ncs, m_oe, m_dird, m_resp, m_ready, m_phi;
  logic [15:0] a_at  [0:31];
  logic [7:0]  d_at  [0:31];
  logic [7:0]  rd_at [0:31];
  logic        last_at [0:31];

  always #5 clk = ~clk;

  // Cartridge model: answers reads with a value derived from the low address byte.
  assign cart_d_in = cart_nrd ? 8'h00 : (cart_a[7:0] ^ 8'h9E);

  cartridge_bus_engine dut (
    .clock_i       (clk),
    .reset_ni      (reset_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_write_i   (req_write),
    .req_addr_i    (req_addr),
    .req_wdata_i   (req_wdata),
    .req_len_i     (req_len),
    .resp_valid_o  (resp_valid),
    .resp_rdata_o  (resp_rdata),
    .resp_last_o   (resp_last),
    .cart_a_o      (cart_a),
    .cart_d_out_o  (cart_d_out),
    .cart_d_oe_o   (cart_d_oe),
    .cart_d_in_i   (cart_d_in),
    .cart_nrd_o    (cart_nrd),
    .cart_nwr_o    (cart_nwr),
    .cart_ncs_o    (cart_ncs),
    .cart_phi_o    (cart_phi),
    .dir_a_lo_o    (dir_a_lo),
    .dir_a_hi_o    (dir_a_hi),
    .dir_ctrl_o    (dir_ctrl),
    .dir_d_o       (dir_d),
    .shifter_n_oe_o(shifter_n_oe)
  );

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (!cart_nrd && !cart_nwr) begin
        errors++;
        $display("FAIL strobe_overlap: nrd=%b nwr=%b required not both 0", cart_nrd, cart_nwr);
      end
      checks++;
      if (cart_d_oe && !cart_nrd) begin
        errors++;
        $display("FAIL oe_during_read: oe=%b nrd=%b required oe=0 while nrd=0", cart_d_oe,
                 cart_nrd);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [15:0] addr, input logic [7:0] wd,
                       input logic [7:0] len, input logic hold);
    int waited = 0;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_len   = len;
    req_valid = 1'b1;
    while (!req_ready && waited < 50) begin
      tick();
      waited++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready_timeout: req_ready=%b required 1", req_ready);
    end
    tick();
    if (!hold) req_valid = 1'b0;
  endtask

  // Record cycles 1..n after the acceptance edge; drops req_valid after any handshake.
  task automatic capture(input int n);
    logic take;
    m_nrd = '0; m_nwr = '0; m_ncs = '0; m_oe = '0;
    m_dird = '0; m_resp = '0; m_ready = '0; m_phi = '0;
    for (int k = 1; k <= n; k++) begin
      m_nrd[k]   = ~cart_nrd;
      m_nwr[k]   = ~cart_nwr;
      m_ncs[k]   = ~cart_ncs;
      m_oe[k]    = cart_d_oe;
      m_dird[k]  = dir_d;
      m_resp[k]  = resp_valid;
      m_ready[k] = req_ready;
      m_phi[k]   = cart_phi;
      a_at[k]    = cart_a;
      d_at[k]    = cart_d_out;
      rd_at[k]   = resp_rdata;
      last_at[k] = resp_last;
      take = req_valid && req_ready;
      tick();
      if (take) req_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({req_ready, resp_valid, resp_last, cart_d_oe, dir_d, cart_phi} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: ready/rv/last/oe/dird/phi=%b required 000000",
               {req_ready, resp_valid, resp_last, cart_d_oe, dir_d, cart_phi});
    end
    checks++;
    if ({cart_a, cart_d_out, resp_rdata} !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: a/dout/rdata=%h required 00000000",
               {cart_a, cart_d_out, resp_rdata});
    end
    checks++;
    if ({cart_nrd, cart_nwr, cart_ncs, dir_a_lo, dir_a_hi, dir_ctrl, shifter_n_oe} !== 7'h7F) begin
      errors++;
      $display("FAIL reset_strobes: nrd/nwr/ncs/dirs/snoe=%b required 1111111",
               {cart_nrd, cart_nwr, cart_ncs, dir_a_lo, dir_a_hi, dir_ctrl, shifter_n_oe});
    end
    reset_n = 1'b1;
    checks++;
    if ({shifter_n_oe, req_ready} !== 2'b10) begin
      errors++;
      $display("FAIL release_cycle: snoe/ready=%b required 10", {shifter_n_oe, req_ready});
    end
    tick();
    checks++;
    if ({shifter_n_oe, req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL after_release: snoe/ready=%b required 01", {shifter_n_oe, req_ready});
    end
    mon_en = 1'b1;
  endtask

  task automatic test_single_read();
    issue(1'b0, 16'h0150, 8'h00, 8'h00, 1'b0);
    capture(12);
    checks++;
    if (m_nrd !== 32'h78 || m_phi !== 32'h78 || m_nwr !== 32'h0) begin
      errors++;
      $display("FAIL read_strobes: nrd=%h phi=%h nwr=%h required 78 78 0", m_nrd, m_phi, m_nwr);
    end
    checks++;
    if (m_resp !== 32'h100 || m_ncs !== 32'h0 || m_oe !== 32'h0) begin
      errors++;
      $display("FAIL read_resp_ncs_oe: resp=%h ncs=%h oe=%h required 100 0 0", m_resp, m_ncs, m_oe);
    end
    checks++;
    if ({rd_at[8], last_at[8], a_at[1]} !== {8'hCE, 1'b1, 16'h0150}) begin
      errors++;
      $display("FAIL read_data: rdata=%h last=%b addr=%h required ce 1 0150", rd_at[8],
               last_at[8], a_at[1]);
    end
  endtask

  task automatic test_single_write();
    issue(1'b1, 16'h0000, 8'h0A, 8'h00, 1'b0);
    capture(12);
    checks++;
    if (m_nwr !== 32'h78 || m_nrd !== 32'h0) begin
      errors++;
      $display("FAIL write_strobes: nwr=%h nrd=%h required 78 0", m_nwr, m_nrd);
    end
    checks++;
    if (m_oe !== 32'hFE || m_dird !== 32'hFE) begin
      errors++;
      $display("FAIL write_oe_dir: oe=%h dird=%h required fe fe", m_oe, m_dird);
    end
    checks++;
    if (d_at[1] !== 8'h0A || d_at[7] !== 8'h0A) begin
      errors++;
      $display("FAIL write_dout: c1=%h c7=%h required 0a 0a", d_at[1], d_at[7]);
    end
    checks++;
    if ({m_resp, rd_at[8], last_at[8]} !== {32'h100, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL write_resp: resp=%h rdata=%h last=%b required 100 00 1", m_resp, rd_at[8],
               last_at[8]);
    end
  endtask

  task automatic test_chip_select();
    issue(1'b0, 16'hA000, 8'h00, 8'h00, 1'b0);
    capture(12);
    checks++;
    if (m_ncs !== 32'hFE || rd_at[8] !== 8'h9E) begin
      errors++;
      $display("FAIL ncs_sram: ncs_low=%h rdata=%h required fe 9e", m_ncs, rd_at[8]);
    end
    issue(1'b0, 16'hC000, 8'h00, 8'h00, 1'b0);
    capture(12);
    checks++;
    if (m_ncs !== 32'h0 || m_resp !== 32'h100) begin
      errors++;
      $display("FAIL ncs_wram: ncs_low=%h resp=%h required 0 100", m_ncs, m_resp);
    end
  endtask

  task automatic test_burst();
    issue(1'b0, 16'hFFFE, 8'h00, 8'd2, 1'b0);
    capture(26);
`ifdef CART_BUS_BURST_EN
    checks++;
    if (m_resp !== 32'h408100 || m_nrd !== 32'h1E3C78) begin
      errors++;
      $display("FAIL burst_timing: resp=%h nrd=%h required 408100 1e3c78", m_resp, m_nrd);
    end
    checks++;
    if (a_at[1] !== 16'hFFFE || a_at[8] !== 16'hFFFF || a_at[15] !== 16'h0000) begin
      errors++;
      $display("FAIL burst_addr: %h %h %h required fffe ffff 0000", a_at[1], a_at[8], a_at[15]);
    end
    checks++;
    if ({rd_at[8], rd_at[15], rd_at[22]} !== 24'h60619E) begin
      errors++;
      $display("FAIL burst_rdata: %h %h %h required 60 61 9e", rd_at[8], rd_at[15], rd_at[22]);
    end
    checks++;
    if ({last_at[8], last_at[15], last_at[22]} !== 3'b001 || m_ready !== 32'h3E00000) begin
      errors++;
      $display("FAIL burst_last_ready: last=%b ready=%h required 001 3e00000",
               {last_at[8], last_at[15], last_at[22]}, m_ready);
    end
`else
    checks++;
    if (m_resp !== 32'h100 || m_nrd !== 32'h78) begin
      errors++;
      $display("FAIL len_ignored: resp=%h nrd=%h required 100 78", m_resp, m_nrd);
    end
    checks++;
    if (rd_at[8] !== 8'h60 || last_at[8] !== 1'b1) begin
      errors++;
      $display("FAIL len_ignored_data: rdata=%h last=%b required 60 1", rd_at[8], last_at[8]);
    end
`endif
  endtask

  task automatic test_reset_mid_write();
    issue(1'b1, 16'h2000, 8'h55, 8'h00, 1'b0);
    repeat (3) tick();
    reset_n = 1'b0;
    tick();
    checks++;
    if ({cart_nwr, cart_d_oe, resp_valid, req_ready, shifter_n_oe} !== 5'b10001) begin
      errors++;
      $display("FAIL midreset_state: nwr/oe/rv/ready/snoe=%b required 10001",
               {cart_nwr, cart_d_oe, resp_valid, req_ready, shifter_n_oe});
    end
    reset_n = 1'b1;
    checks++;
    if ({shifter_n_oe, req_ready} !== 2'b10) begin
      errors++;
      $display("FAIL midreset_release: snoe/ready=%b required 10", {shifter_n_oe, req_ready});
    end
    tick();
    checks++;
    if ({shifter_n_oe, req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL midreset_after: snoe/ready=%b required 01", {shifter_n_oe, req_ready});
    end
    capture(10);
    checks++;
    if (m_resp !== 32'h0 || m_nwr !== 32'h0) begin
      errors++;
      $display("FAIL midreset_no_resp: resp=%h nwr=%h required 0 0", m_resp, m_nwr);
    end
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 16'h2000, 8'h11, 8'h00, 1'b1);
    req_addr  = 16'h2001;
    req_wdata = 8'h22;
    capture(16);
    checks++;
    if (m_resp !== 32'h8100 || m_nwr !== 32'h3C78 || m_nrd !== 32'h0) begin
      errors++;
      $display("FAIL b2b_strobes: resp=%h nwr=%h nrd=%h required 8100 3c78 0", m_resp, m_nwr,
               m_nrd);
    end
    checks++;
    if (m_ready !== 32'h1C080 || m_oe !== 32'h7FFE) begin
      errors++;
      $display("FAIL b2b_ready_oe: ready=%h oe=%h required 1c080 7ffe", m_ready, m_oe);
    end
    checks++;
    if ({a_at[7], a_at[8], d_at[7], d_at[8]} !== {16'h2000, 16'h2001, 8'h11, 8'h22}) begin
      errors++;
      $display("FAIL b2b_second_setup: a7=%h a8=%h d7=%h d8=%h required 2000 2001 11 22",
               a_at[7], a_at[8], d_at[7], d_at[8]);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 16'h0000;
    req_wdata = 8'h00;
    req_len   = 8'h00;
    repeat (3) tick();
    test_reset();
    test_single_read();
    test_single_write();
    test_chip_select();
    test_burst();
    test_reset_mid_write();
    test_back_to_back();
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
